sample_iterator: RTL and testbench

SAMPLE_ITERATOR -- requirements
Module: sample_iterator

---
 rtl/sample_iterator.sv | 206 ++++++++++++++++++++
 tb/tb_sample_iterator.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_iterator.sv
// Walks every sample-grid point inside a triangle's bounding box in raster
// order (x fastest), one sample per non-held cycle, one bubble between tris.
// Optional macro: SAMPLE_ITER_CLAMP_EN clamps the box to the screen.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   tri_R13S          triangle vertices in (signed fixed point)
//   color_R13U        triangle color in
//   box_R13S          bbox [0]=lower-left [1]=upper-right, [.][0]=x [.][1]=y
//   validTri_R13H     triangle/box valid
//   halt_RnnnnL       1 = a triangle is accepted this cycle
//   hold_R16H         downstream stall
//   screen_RnnnnS     screen width/height (used only when clamping)
//   subSample_RnnnnU  one-hot MSAA: [0]=64x [1]=16x [2]=4x [3]=1x
//   tri_R16S          latched triangle
//   color_R16U        latched color
//   sample_R16S       current sample x,y
//   validSamp_R16H    sample_R16S valid
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS-1:0][AXIS-1:0],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS-1:0],
  input  logic signed [SIGFIG-1:0] box_R13S [1:0][1:0],
  input  logic                     validTri_R13H,
  output logic                     halt_RnnnnL,
  input  logic                     hold_R16H,
  input  logic signed [SIGFIG-1:0] screen_RnnnnS [1:0],
  input  logic        [3:0]        subSample_RnnnnU,
  output logic signed [SIGFIG-1:0] tri_R16S [VERTS-1:0][AXIS-1:0],
  output logic        [SIGFIG-1:0] color_R16U [COLORS-1:0],
  output logic signed [SIGFIG-1:0] sample_R16S [1:0],
  output logic                     validSamp_R16H
);

  // One extra bit so x+step never wraps past the box edge.
  localparam int W = SIGFIG + 1;

  typedef enum logic {
    ST_WAIT,
    ST_TEST
  } state_e;

  function automatic logic signed [W-1:0] sx(
    input logic signed [SIGFIG-1:0] v
  );
    return {v[SIGFIG-1], v};
  endfunction

  state_e                  state_q, state_d;
  logic                    halt_q, halt_d;
  logic                    valid_q, valid_d;
  logic signed [SIGFIG-1:0] sample_q [1:0];
  logic signed [SIGFIG-1:0] sample_d [1:0];
  logic signed [SIGFIG-1:0] tri_q [VERTS-1:0][AXIS-1:0];
  logic signed [SIGFIG-1:0] tri_d [VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] color_q [COLORS-1:0];
  logic        [SIGFIG-1:0] color_d [COLORS-1:0];
  logic signed [W-1:0]     llx_q, llx_d;
  logic signed [W-1:0]     ury_q, ury_d;
  logic signed [W-1:0]     urx_q, urx_d;
  logic signed [W-1:0]     step_q, step_d;

  logic        [1:0]       ss_lg2;
  logic        [4:0]       shamt_c;
  logic signed [W-1:0]     step_c;
  logic signed [W-1:0]     mask_c;
  logic signed [W-1:0]     llx_c, lly_c;
  logic signed [W-1:0]     urx_c, ury_c;
  logic signed [W-1:0]     llx_f, lly_f;
  logic                    empty_c;
  logic signed [W-1:0]     nx_c, ny_c;

  // Sample spacing: log2 of samples per pixel edge.
  always_comb begin
    ss_lg2 = 2'd0;
    unique case (1'b1)
      subSample_RnnnnU[0]: ss_lg2 = 2'd3;
      subSample_RnnnnU[1]: ss_lg2 = 2'd2;
      subSample_RnnnnU[2]: ss_lg2 = 2'd1;
      subSample_RnnnnU[3]: ss_lg2 = 2'd0;
      default:             ss_lg2 = 2'd0;
    endcase
  end

  assign shamt_c = 5'(RADIX - int'(ss_lg2));
  assign step_c  = W'(1) << shamt_c;
  assign mask_c  = ~(step_c - W'(1));

  // Incoming box, optionally clamped, then ll snapped to the grid.
  always_comb begin
    llx_c = sx(box_R13S[0][0]);
    lly_c = sx(box_R13S[0][1]);
    urx_c = sx(box_R13S[1][0]);
    ury_c = sx(box_R13S[1][1]);
`ifdef SAMPLE_ITER_CLAMP_EN
    if (llx_c[W-1]) llx_c = '0;
    if (lly_c[W-1]) lly_c = '0;
    if (urx_c > sx(screen_RnnnnS[0]) - step_c)
      urx_c = sx(screen_RnnnnS[0]) - step_c;
    if (ury_c > sx(screen_RnnnnS[1]) - step_c)
      ury_c = sx(screen_RnnnnS[1]) - step_c;
`endif
    empty_c = (urx_c < llx_c) || (ury_c < lly_c);
    llx_f   = llx_c & mask_c;
    lly_f   = lly_c & mask_c;
  end

`ifndef SAMPLE_ITER_CLAMP_EN
  logic unused_screen;
  assign unused_screen = ^{screen_RnnnnS[0], screen_RnnnnS[1]};
`endif

  assign nx_c = sx(sample_q[0]) + step_q;
  assign ny_c = sx(sample_q[1]) + step_q;

  always_comb begin
    state_d  = state_q;
    halt_d   = halt_q;
    valid_d  = valid_q;
    sample_d = sample_q;
    tri_d    = tri_q;
    color_d  = color_q;
    llx_d    = llx_q;
    urx_d    = urx_q;
    ury_d    = ury_q;
    step_d   = step_q;
    unique case (state_q)
      ST_WAIT: begin
        halt_d  = 1'b1;
        valid_d = 1'b0;
        // An empty box is swallowed here and never reaches TEST.
        if (validTri_R13H && !empty_c) begin
          tri_d       = tri_R13S;
          color_d     = color_R13U;
          llx_d       = llx_f;
          urx_d       = urx_c;
          ury_d       = ury_c;
          step_d      = step_c;
          sample_d[0] = llx_f[SIGFIG-1:0];
          sample_d[1] = lly_f[SIGFIG-1:0];
          state_d     = ST_TEST;
          halt_d      = 1'b0;
          valid_d     = 1'b1;
        end
      end
      ST_TEST: begin
        if (!hold_R16H) begin
          if (nx_c <= urx_q) begin
            sample_d[0] = nx_c[SIGFIG-1:0];
          end else if (ny_c <= ury_q) begin
            sample_d[0] = llx_q[SIGFIG-1:0];
            sample_d[1] = ny_c[SIGFIG-1:0];
          end else begin
            state_d = ST_WAIT;
            halt_d  = 1'b1;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_WAIT;
        halt_d  = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_WAIT;
      halt_q   <= 1'b1;
      valid_q  <= 1'b0;
      sample_q <= '{default: '0};
      tri_q    <= '{default: '0};
      color_q  <= '{default: '0};
      llx_q    <= '0;
      urx_q    <= '0;
      ury_q    <= '0;
      step_q   <= '0;
    end else begin
      state_q  <= state_d;
      halt_q   <= halt_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
      tri_q    <= tri_d;
      color_q  <= color_d;
      llx_q    <= llx_d;
      urx_q    <= urx_d;
      ury_q    <= ury_d;
      step_q   <= step_d;
    end
  end

  assign halt_RnnnnL    = halt_q;
  assign validSamp_R16H = valid_q;
  assign sample_R16S    = sample_q;
  assign tri_R16S       = tri_q;
  assign color_R16U     = color_q;

endmodule

// File: tb/tb_sample_iterator.sv
// Bench for sample_iterator: directed cases plus random boxes, checked
// against a nested-loop raster model of the expected sample list.
module tb_sample_iterator;

  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;

  logic clk = 1'b0;
  logic rst;
  logic signed [SIGFIG-1:0] tri_in [VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] color_in [COLORS-1:0];
  logic signed [SIGFIG-1:0] box_in [1:0][1:0];
  logic                     valid_in;
  logic                     halt_out;
  logic                     hold_in;
  logic signed [SIGFIG-1:0] screen_in [1:0];
  logic        [3:0]        subsample;
  logic signed [SIGFIG-1:0] tri_out [VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] color_out [COLORS-1:0];
  logic signed [SIGFIG-1:0] sample_out [1:0];
  logic                     valid_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sample_iterator #(
    .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS),
    .AXIS(AXIS), .COLORS(COLORS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tri_R13S(tri_in),
    .color_R13U(color_in),
    .box_R13S(box_in),
    .validTri_R13H(valid_in),
    .halt_RnnnnL(halt_out),
    .hold_R16H(hold_in),
    .screen_RnnnnS(screen_in),
    .subSample_RnnnnU(subsample),
    .tri_R16S(tri_out),
    .color_R16U(color_out),
    .sample_R16S(sample_out),
    .validSamp_R16H(valid_out)
  );

  task automatic check(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pk_tri_in();
    logic [255:0] r;
    r = '0;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        r[(v*AXIS+a)*SIGFIG +: SIGFIG] = tri_in[v][a];
    return r;
  endfunction

  function automatic logic [255:0] pk_tri_out();
    logic [255:0] r;
    r = '0;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        r[(v*AXIS+a)*SIGFIG +: SIGFIG] = tri_out[v][a];
    return r;
  endfunction

  function automatic logic [255:0] pk_col_in();
    logic [255:0] r;
    r = '0;
    for (int c = 0; c < COLORS; c++)
      r[c*SIGFIG +: SIGFIG] = color_in[c];
    return r;
  endfunction

  function automatic logic [255:0] pk_col_out();
    logic [255:0] r;
    r = '0;
    for (int c = 0; c < COLORS; c++)
      r[c*SIGFIG +: SIGFIG] = color_out[c];
    return r;
  endfunction

  function automatic logic [255:0] pk_samp();
    return {208'd0, sample_out[0], sample_out[1]};
  endfunction

  function automatic logic [255:0] pk_xy(input int x, input int y);
    return {208'd0, SIGFIG'(x), SIGFIG'(y)};
  endfunction

  function automatic int lg2(input logic [3:0] ss);
    if (ss[0]) return 3;
    if (ss[1]) return 2;
    if (ss[2]) return 1;
    return 0;
  endfunction

  task automatic set_box(input int llx, input int lly,
                         input int urx, input int ury);
    box_in[0][0] = SIGFIG'(llx);
    box_in[0][1] = SIGFIG'(lly);
    box_in[1][0] = SIGFIG'(urx);
    box_in[1][1] = SIGFIG'(ury);
  endtask

  task automatic scramble();
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++)
        tri_in[v][a] = SIGFIG'($urandom);
    for (int c = 0; c < COLORS; c++)
      color_in[c] = SIGFIG'($urandom);
  endtask

  // Present one triangle and follow it to the bubble cycle.
  task automatic run_tri(input string tag,
                         input int llx, input int lly,
                         input int urx, input int ury,
                         input logic [3:0] ss,
                         input logic [31:0] hmask,
                         input bit rnd);
    int step, fx, fy, n, i, c;
    int cx0, cy0, cx1, cy1;
    int ex[$];
    int ey[$];
    logic [255:0] et, ec;
    bit h, ok;
    step = 1 << (RADIX - lg2(ss));
    cx0 = llx; cy0 = lly; cx1 = urx; cy1 = ury;
`ifdef SAMPLE_ITER_CLAMP_EN
    if (cx0 < 0) cx0 = 0;
    if (cy0 < 0) cy0 = 0;
    if (cx1 > int'(screen_in[0]) - step) cx1 = int'(screen_in[0]) - step;
    if (cy1 > int'(screen_in[1]) - step) cy1 = int'(screen_in[1]) - step;
`endif
    if (cx1 >= cx0 && cy1 >= cy0) begin
      fx = cx0 & ~(step - 1);
      fy = cy0 & ~(step - 1);
      for (int y = fy; y <= cy1; y += step)
        for (int x = fx; x <= cx1; x += step) begin
          ex.push_back(x);
          ey.push_back(y);
        end
    end
    n = ex.size();
    check({tag, ":idle_halt"}, halt_out, 1'b1);
    subsample = ss;
    set_box(llx, lly, urx, ury);
    scramble();
    et = pk_tri_in();
    ec = pk_col_in();
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    scramble();
    if (n == 0) begin
      for (int k = 0; k < 2; k++) begin
        check({tag, ":empty_vld"}, valid_out, 1'b0);
        check({tag, ":empty_halt"}, halt_out, 1'b1);
        tick();
      end
      return;
    end
    i = 0; c = 0; ok = 1'b1;
    while (ok && i < n) begin
      if (c > 4*n + 40) begin
        check({tag, ":timeout"}, i, n);
        ok = 1'b0;
      end else begin
        check({tag, ":vld"}, valid_out, 1'b1);
        if (valid_out !== 1'b1) begin
          ok = 1'b0;
        end else begin
          check({tag, ":samp"}, pk_samp(), pk_xy(ex[i], ey[i]));
          check({tag, ":halt"}, halt_out, 1'b0);
          check({tag, ":tri"}, pk_tri_out(), et);
          check({tag, ":col"}, pk_col_out(), ec);
          if (rnd) h = ($urandom_range(0, 3) == 0);
          else     h = (c < 32) ? hmask[c] : 1'b0;
          hold_in = h;
          tick();
          if (!h) i++;
          c++;
        end
      end
    end
    hold_in = 1'b0;
    if (ok) begin
      check({tag, ":bubble_vld"}, valid_out, 1'b0);
      check({tag, ":bubble_halt"}, halt_out, 1'b1);
    end
  endtask

  initial begin
    int ssi, step, llx, lly, w, h;
    logic [3:0] ss;
    rst = 1'b1;
    valid_in = 1'b0;
    hold_in = 1'b0;
    subsample = 4'b1000;
    set_box(0, 0, 0, 0);
    tri_in = '{default: '0};
    color_in = '{default: '0};
    screen_in[0] = SIGFIG'(4096);
    screen_in[1] = SIGFIG'(4096);
    tick();
    tick();
    rst = 1'b0;
    check("rst_halt", halt_out, 1'b1);
    check("rst_vld", valid_out, 1'b0);
    check("rst_samp", pk_samp(), '0);
    check("rst_tri", pk_tri_out(), '0);
    check("rst_col", pk_col_out(), '0);
    tick();

    run_tri("r35", 0, 0, 2048, 1024, 4'b1000, 32'd0, 1'b0);
    run_tri("r36", 512, 512, 1023, 1023, 4'b0100, 32'd0, 1'b0);
    run_tri("r37", 0, 0, 2048, 1024, 4'b1000, 32'b1110, 1'b0);
    run_tri("r38", 1024, 0, 0, 0, 4'b1000, 32'd0, 1'b0);
    run_tri("floor", 300, -700, 1500, 100, 4'b1000, 32'd0, 1'b0);
    run_tri("b2b", 100, 100, 900, 300, 4'b0001, 32'b101, 1'b0);

    // Reset on the third sample, with valid and hold also high.
    subsample = 4'b1000;
    set_box(0, 0, 2048, 1024);
    scramble();
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    check("r39_third", pk_samp(), pk_xy(2048, 0));
    rst = 1'b1;
    hold_in = 1'b1;
    valid_in = 1'b1;
    set_box(4096, 4096, 5120, 5120);
    tick();
    rst = 1'b0;
    hold_in = 1'b0;
    valid_in = 1'b0;
    check("r39_vld", valid_out, 1'b0);
    check("r39_halt", halt_out, 1'b1);
    check("r39_samp", pk_samp(), '0);
    check("r39_tri", pk_tri_out(), '0);
    check("r39_col", pk_col_out(), '0);
    tick();
    check("r39_quiet", valid_out, 1'b0);
    run_tri("r39_next", 3072, 2048, 4096, 3072, 4'b1000, 32'd0, 1'b0);

`ifdef SAMPLE_ITER_CLAMP_EN
    screen_in[0] = SIGFIG'(2048);
    screen_in[1] = SIGFIG'(2048);
    run_tri("r40", -1024, 0, 4096, 0, 4'b1000, 32'd0, 1'b0);
    screen_in[0] = SIGFIG'(4096);
    screen_in[1] = SIGFIG'(4096);
`endif

    for (int t = 0; t < 40; t++) begin
      ssi = $urandom_range(0, 3);
      ss = 4'b0001 << ssi;
      step = 1 << (RADIX - lg2(ss));
      llx = int'($urandom_range(0, 8000)) - 4000;
      lly = int'($urandom_range(0, 8000)) - 4000;
      w = int'($urandom_range(0, 5 * step));
      h = int'($urandom_range(0, 5 * step));
      if ($urandom_range(0, 7) == 0) w = -int'($urandom_range(1, 500));
      if ($urandom_range(0, 7) == 0) h = -int'($urandom_range(1, 500));
      run_tri("rand", llx, lly, llx + w, lly + h, ss, 32'd0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
